// File: rtl/icache_store_2way_if.sv
// Request/response bundle between the I-fetch control and the two-way icache store.
//   master (fetch side): drives addr, rdvld, wrvld, wrdata, flush; observes busy, hit,
//                        hit_way, rddata.
//   slave  (store side): the reverse directions.
interface icache_store_2way_if #(
   parameter int unsigned ADDR_W = 15,
   parameter int unsigned LINE_W = 256
);
   logic [ADDR_W-1:0] addr;
   logic              rdvld;
   logic              wrvld;
   logic [LINE_W-1:0] wrdata;
   logic              flush;
   logic              busy;
   logic              hit;
   logic              hit_way;
   logic [LINE_W-1:0] rddata;

   modport master (
      output addr, rdvld, wrvld, wrdata, flush,
      input  busy, hit, hit_way, rddata
   );

   modport slave (
      input  addr, rdvld, wrvld, wrdata, flush,
      output busy, hit, hit_way, rddata
   );
endinterface

// File: rtl/icache_store_2way.sv
// Two-way set-associative instruction-cache storage: tag, valid, per-set LRU and line data.
// Registered tag lookup (one-cycle), victim-way refill, and a sequential flush engine that
// invalidates one set per cycle.
// Ports:
//   clk  - clock, rising-edge
//   rst  - asynchronous active-low reset
//   bus  - slave side of icache_store_2way_if (addr/rdvld/wrvld/wrdata/flush in,
//          busy/hit/hit_way/rddata out)
module icache_store_2way #(
   parameter int unsigned SETS   = 8,
   parameter int unsigned IDX_W  = 3,
   parameter int unsigned TAG_W  = 7,
   parameter int unsigned OFF_W  = 5,
   parameter int unsigned LINE_W = 256,
   parameter int unsigned ADDR_W = 15
) (
   input logic                clk,
   input logic                rst,
   icache_store_2way_if.slave bus
);

   localparam int unsigned TagLsb = IDX_W + OFF_W;
   localparam logic [IDX_W-1:0] LastSet = IDX_W'(SETS - 1);

   typedef enum logic [0:0] {StIdle, StFlush} state_e;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              hit_q, hit_d;
   logic              hit_way_q, hit_way_d;
   logic [LINE_W-1:0] rddata_q, rddata_d;
   logic [SETS-1:0]   valid0_q, valid0_d;
   logic [SETS-1:0]   valid1_q, valid1_d;
   logic [SETS-1:0]   lru_q, lru_d;

   // Tag and data arrays carry no reset; valid bits gate every use of them.
   logic [TAG_W-1:0]  tag0_q  [SETS];
   logic [TAG_W-1:0]  tag1_q  [SETS];
   logic [LINE_W-1:0] data0_q [SETS];
   logic [LINE_W-1:0] data1_q [SETS];

   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  req_idx;
   logic              blocked;
   logic              wr_en;
   logic              rd_en;
   logic              match0;
   logic              match1;
   logic              victim;
   logic              unused_off;

   assign req_tag    = bus.addr[ADDR_W-1:TagLsb];
   assign req_idx    = bus.addr[TagLsb-1:OFF_W];
   assign unused_off = ^bus.addr[OFF_W-1:0];

   // Requests are dropped for the whole sweep and in the cycle the flush pulse is taken.
   assign blocked = (state_q == StFlush) | bus.flush;
   assign wr_en   = bus.wrvld & ~blocked;
   assign rd_en   = bus.rdvld & ~bus.wrvld & ~blocked;

   assign match0 = valid0_q[req_idx] && (tag0_q[req_idx] == req_tag);
   assign match1 = valid1_q[req_idx] && (tag1_q[req_idx] == req_tag);

   // Fill an empty way first (way0 preferred), otherwise the least-recently-used way.
   always_comb begin
      if (!valid0_q[req_idx]) begin
         victim = 1'b0;
      end else if (!valid1_q[req_idx]) begin
         victim = 1'b1;
      end else begin
         victim = lru_q[req_idx];
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      hit_d     = 1'b0;
      hit_way_d = hit_way_q;
      rddata_d  = rddata_q;
      valid0_d  = valid0_q;
      valid1_d  = valid1_q;
      lru_d     = lru_q;

      unique case (state_q)
         StIdle: begin
            if (bus.flush) begin
               state_d = StFlush;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         StFlush: begin
            valid0_d[cnt_q] = 1'b0;
            valid1_d[cnt_q] = 1'b0;
            lru_d[cnt_q]    = 1'b0;
            cnt_d           = cnt_q + 1'b1;
            if (cnt_q == LastSet) begin
               state_d = StIdle;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase

      if (wr_en) begin
         if (victim) begin
            valid1_d[req_idx] = 1'b1;
         end else begin
            valid0_d[req_idx] = 1'b1;
         end
         lru_d[req_idx] = ~victim;
      end

      // A double match cannot arise from fills; way0 wins if it ever does.
      if (rd_en && (match0 || match1)) begin
         hit_d          = 1'b1;
         hit_way_d      = ~match0;
         rddata_d       = match0 ? data0_q[req_idx] : data1_q[req_idx];
         lru_d[req_idx] = match0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         hit_q     <= 1'b0;
         hit_way_q <= 1'b0;
         rddata_q  <= '0;
         valid0_q  <= '0;
         valid1_q  <= '0;
         lru_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         hit_q     <= hit_d;
         hit_way_q <= hit_way_d;
         rddata_q  <= rddata_d;
         valid0_q  <= valid0_d;
         valid1_q  <= valid1_d;
         lru_q     <= lru_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (victim) begin
            tag1_q[req_idx]  <= req_tag;
            data1_q[req_idx] <= bus.wrdata;
         end else begin
            tag0_q[req_idx]  <= req_tag;
            data0_q[req_idx] <= bus.wrdata;
         end
      end
   end

   assign bus.busy    = busy_q;
   assign bus.hit     = hit_q;
   assign bus.hit_way = hit_way_q;
   assign bus.rddata  = rddata_q;

endmodule
